gb_camera_ctrl: RTL and testbench
=================================

# gb_camera_ctrl

Parametrised successor to the Game Boy Camera mapper. It provides ROM/RAM banking and a stored camera register file, and runs a cycle-timed capture sequencer whose busy bit software can poll. It sits in the cart mapper slot beside the other mappers. Its outputs are valid only while `enable` is high. Optionally, on capture completion it writes a synthetic image into cart RAM bank 0 through a dedicated write port.

## Interface
Parameters:
- ROM_BANK_W, 7, ROM bank register width (up to 128 × 16 KiB banks)
- RAM_BANK_W, 4, RAM bank register width
- CAP_BASE_CYCLES, 32446, fixed capture overhead, in ce_cpu pulses
- CAP_EXP_SHIFT, 4, exposure multiplier as a left shift (×16)

Ports (one clock; reset is synchronous and active-high):
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- enable  in  1  mapper selected; low = hold all state at reset values
- ce_cpu  in  1  CPU clock enable; all register writes and timer ticks qualify on it
- cart_addr  in  16  CPU address
- cart_wr  in  1  CPU write strobe
- cart_di  in  8  CPU write data
- cram_di  in  8  cart RAM read data
- cram_do  out  8  data returned to CPU for A000–BFFF
- cram_addr  out  RAM_BANK_W+13  cart RAM address for CPU access
- mbc_bank  out  ROM_BANK_W+1  {rom_bank, cart_addr[13]} in 8 KiB units
- ram_enabled  out  1  CPU RAM write permitted
- has_battery  out  1  constant 1
- ram_mask  in  RAM_BANK_W  RAM bank mirror mask
- rom_mask  in  ROM_BANK_W  ROM bank mirror mask
- cap_wr  out  1  capture write request
- cap_addr  out  13  capture write offset in RAM bank 0
- cap_data  out  8  capture write data
- cap_ack  in  1  write accepted; the top level grants the CPU priority
- cap_busy  out  1  capture in progress

## Operation
- CPU writes to 0000–7FFF when ce_cpu & cart_wr:
  - 0000–1FFF: ram_enable = (di[3:0]==A)
  - 2000–3FFF: rom_bank_reg = di[ROM_BANK_W-1:0]
  - 4000–5FFF: if di[4], cam_en=1; otherwise cam_en=0 and ram_bank_reg=di
- Address mapping:
  - ROM bank forced to 0 for 0000–3FFF, then ANDed with rom_mask.
  - RAM bank ANDed with ram_mask.
- Register file, active when cam_en and the address is A000–BFFF. Index is cart_addr[6:0].
  - reg0 holds bits [2:0]. Writing bit0=1 while IDLE starts a capture. Writing bit0 while busy is ignored. Bits [2:1] are always stored.
  - reg1–reg5 are stored. exposure = {reg2, reg3}.
  - Writes to indexes 06–7F are dropped.
- Reads:
  - cam_en: A000 returns {5'b0, reg0[2:1], cap_busy}; all other indexes return 00.
  - RAM mode: returns 00 while cap_busy, else cram_di.
- ram_enabled = ram_enable & ~cam_en & ~cap_busy.
- Capture duration D = CAP_BASE_CYCLES + (reg1[7] ? 0 : 512) + (exposure << CAP_EXP_SHIFT).
  - Computed in 22 bits; cannot overflow.
  - Latched at start; later register writes do not alter a running capture.
- State machine:
  - IDLE → EXPOSE on start.
  - EXPOSE → FILL (macro on) or IDLE (macro off) when the counter reaches 0.
  - FILL → IDLE after the final cap_ack.
  - frame_cnt (8 bits) increments on each completion and wraps FF→00.
- cap_busy = (state != IDLE).
- Abort: reset or enable=0 in any state:
  - returns to IDLE next cycle and drops cap_wr;
  - rom_bank_reg=1, all other registers and frame_cnt=0.

## Timing
- Reset values: cram_do=00 in cam mode, mbc_bank={1,addr13}, ram_enabled=0, cap_wr=0, cap_addr=0100, cap_data=00, cap_busy=0, has_battery=1.
- Register writes take effect on the clk_sys edge of the qualifying ce_cpu pulse.
- Start write: cap_busy=1 from the next cycle. The counter loads D-1 and decrements once per ce_cpu pulse. EXPOSE exits on the ce_cpu pulse where the counter is 0, i.e. exactly D pulses.
- FILL handshake:
  - cap_wr, cap_addr and cap_data stay stable until the cycle cap_ack is high.
  - The next beat is presented the following cycle, so the peak rate is 1 write per 2 clk_sys cycles.
  - cap_ack without cap_wr is ignored.
- cap_busy falls the cycle after the last ack (offset 0EFF).

## Configuration
- GB_CAMERA_TESTPATTERN_EN defined:
  - FILL writes 3584 bytes at offsets 0100–0EFF in ascending order.
  - data = offset[7:0] ^ frame_cnt, using frame_cnt before its increment.
- Undefined:
  - no FILL state; cap_wr tied 0 and cap_addr/cap_data tied 0.
  - EXPOSE returns directly to IDLE.

## Test plan
- Banking: write 2000←45, read 4000 → mbc_bank={45,0}; with rom_mask=1F → {05,0}. Write 0000←0A, 4000←03 → cram_addr bank 3, ram_enabled=1.
- Timing: cam_en, reg1=80, reg2/3=0000, A000←01 → cap_busy high for exactly 32446 ce_cpu pulses; A000 reads 01 during, 00 after.
- Exposure: reg1=00, exposure=0010 → D=33214. Re-writing exposure mid-capture does not change D.
- Fill (macro on): first capture writes 0100←00, 01FF←FF, 0EFF←FF. Second capture writes 0100←01. cap_ack held low for 10 cycles → cap_wr/cap_addr stable.
- Abort: enable=0 mid-FILL → next cycle cap_wr=0, cap_busy=0, rom bank=1. Restart capture → first write is again at 0100.
- RAM lockout: during capture in RAM mode, 0000←0A gives ram_enabled=0 and reads return 00. Both recover after completion.

Source files
------------

// File: rtl/gb_camera_ctrl.sv
// Game Boy Camera mapper: ROM/RAM banking, camera register file and a cycle-timed capture sequencer.
// Define GB_CAMERA_TESTPATTERN_EN to write a synthetic image into cart RAM bank 0 after each capture.
module gb_camera_ctrl #(
    parameter int ROM_BANK_W      = 7,
    parameter int RAM_BANK_W      = 4,
    parameter int CAP_BASE_CYCLES = 32446,
    parameter int CAP_EXP_SHIFT   = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  ce_cpu,
    input  logic [15:0]           cart_addr,
    input  logic                  cart_wr,
    input  logic [7:0]            cart_di,
    input  logic [7:0]            cram_di,
    output logic [7:0]            cram_do,
    output logic [RAM_BANK_W+12:0] cram_addr,
    output logic [ROM_BANK_W:0]   mbc_bank,
    output logic                  ram_enabled,
    output logic                  has_battery,
    input  logic [RAM_BANK_W-1:0] ram_mask,
    input  logic [ROM_BANK_W-1:0] rom_mask,
    output logic                  cap_wr,
    output logic [12:0]           cap_addr,
    output logic [7:0]            cap_data,
    input  logic                  cap_ack,
    output logic                  cap_busy
);

    typedef enum logic [1:0] {IDLE, EXPOSE, FILL} state_t;

    state_t                state_q, state_d;
    logic                  clr;
    logic                  ram_enable;
    logic [ROM_BANK_W-1:0] rom_bank_reg;
    logic [RAM_BANK_W-1:0] ram_bank_reg;
    logic                  cam_en;
    logic [1:0]            reg0_hi;
    logic [7:0]            reg1, reg2, reg3, reg4, reg5;
    logic [21:0]           cnt;
    logic [21:0]           dur;
    logic [7:0]            frame_cnt;
    logic                  cpu_wr, mbc_wr, cam_wr, start, exp_done;
    logic [6:0]            idx;
    logic [ROM_BANK_W-1:0] rom_sel;
    logic                  unused_bits;

    // Disabling the mapper is treated exactly like reset.
    assign clr      = reset | ~enable;
    assign cpu_wr   = ce_cpu & cart_wr;
    assign mbc_wr   = cpu_wr & ~cart_addr[15];
    assign cam_wr   = cpu_wr & cam_en & (cart_addr[15:13] == 3'b101);
    assign idx      = cart_addr[6:0];
    assign start    = cam_wr & (idx == 7'd0) & cart_di[0] & (state_q == IDLE);
    assign exp_done = (state_q == EXPOSE) & ce_cpu & (cnt == 22'd0);
    assign cap_busy = (state_q != IDLE);

    assign dur = 22'(CAP_BASE_CYCLES) + (reg1[7] ? 22'd0 : 22'd512)
               + (22'({reg2, reg3}) << CAP_EXP_SHIFT);

    assign rom_sel     = (cart_addr[15:14] == 2'b00) ? '0 : rom_bank_reg;
    assign mbc_bank    = {rom_sel & rom_mask, cart_addr[13]};
    assign cram_addr   = {ram_bank_reg & ram_mask, cart_addr[12:0]};
    assign ram_enabled = ram_enable & ~cam_en & ~cap_busy;
    assign has_battery = 1'b1;

    always_comb begin
        cram_do = 8'h00;
        if (cam_en) begin
            if (idx == 7'd0) cram_do = {5'b0, reg0_hi, cap_busy};
        end else if (!cap_busy) begin
            cram_do = cram_di;
        end
    end

`ifdef GB_CAMERA_TESTPATTERN_EN
    logic [12:0] fill_addr;
    logic        cap_wr_q;
    logic        fill_last;

    assign fill_last   = (state_q == FILL) & cap_wr_q & cap_ack & (fill_addr == 13'h0EFF);
    assign cap_wr      = cap_wr_q;
    assign cap_addr    = fill_addr;
    assign cap_data    = fill_addr[7:0] ^ frame_cnt;
    assign unused_bits = &{1'b0, reg4, reg5};
`else
    assign cap_wr      = 1'b0;
    assign cap_addr    = 13'h0000;
    assign cap_data    = 8'h00;
    assign unused_bits = &{1'b0, reg4, reg5, cap_ack, frame_cnt};
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EXPOSE;
`ifdef GB_CAMERA_TESTPATTERN_EN
            EXPOSE:  if (exp_done) state_d = FILL;
            FILL:    if (fill_last) state_d = IDLE;
`else
            EXPOSE:  if (exp_done) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            ram_enable   <= 1'b0;
            rom_bank_reg <= ROM_BANK_W'(1);
            ram_bank_reg <= '0;
            cam_en       <= 1'b0;
            reg0_hi      <= 2'b00;
            reg1         <= 8'h00;
            reg2         <= 8'h00;
            reg3         <= 8'h00;
            reg4         <= 8'h00;
            reg5         <= 8'h00;
        end else begin
            if (mbc_wr) begin
                case (cart_addr[14:13])
                    2'b00: ram_enable <= (cart_di[3:0] == 4'hA);
                    2'b01: rom_bank_reg <= cart_di[ROM_BANK_W-1:0];
                    2'b10: begin
                        if (cart_di[4]) begin
                            cam_en <= 1'b1;
                        end else begin
                            cam_en       <= 1'b0;
                            ram_bank_reg <= cart_di[RAM_BANK_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
            // The start bit is not stored; only the mode bits persist.
            if (cam_wr) begin
                case (idx)
                    7'd0:    reg0_hi <= cart_di[2:1];
                    7'd1:    reg1    <= cart_di;
                    7'd2:    reg2    <= cart_di;
                    7'd3:    reg3    <= cart_di;
                    7'd4:    reg4    <= cart_di;
                    7'd5:    reg5    <= cart_di;
                    default: ;
                endcase
            end
        end
    end

    // Duration is latched into the counter at start, so later register writes cannot stretch a capture.
    always_ff @(posedge clk_sys) begin
        if (clr) begin
            cnt       <= 22'd0;
            frame_cnt <= 8'h00;
        end else begin
            if (start)
                cnt <= dur - 22'd1;
            else if ((state_q == EXPOSE) && ce_cpu && (cnt != 22'd0))
                cnt <= cnt - 22'd1;
`ifdef GB_CAMERA_TESTPATTERN_EN
            if (fill_last) frame_cnt <= frame_cnt + 8'd1;
`else
            if (exp_done) frame_cnt <= frame_cnt + 8'd1;
`endif
        end
    end

`ifdef GB_CAMERA_TESTPATTERN_EN
    // One beat per two cycles: cap_wr drops for a cycle after each accepted write.
    always_ff @(posedge clk_sys) begin
        if (clr) begin
            fill_addr <= 13'h0100;
            cap_wr_q  <= 1'b0;
        end else if (exp_done) begin
            fill_addr <= 13'h0100;
            cap_wr_q  <= 1'b1;
        end else if (state_q == FILL) begin
            if (cap_wr_q && cap_ack) begin
                cap_wr_q  <= 1'b0;
                fill_addr <= fill_last ? 13'h0100 : fill_addr + 13'd1;
            end else if (!cap_wr_q) begin
                cap_wr_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gb_camera_ctrl.sv
// Directed self-checking bench for gb_camera_ctrl (banking, capture timing, fill, abort, RAM lockout).
module tb_gb_camera_ctrl;

`ifdef GB_CAMERA_TESTPATTERN_EN
    localparam int BASE = 2000;
`else
    localparam int BASE = 32446;
`endif

    logic        clk_sys = 1'b0;
    logic        reset, enable, ce_cpu, cart_wr, cap_ack;
    logic [15:0] cart_addr;
    logic [7:0]  cart_di, cram_di, cram_do, cap_data;
    logic [16:0] cram_addr;
    logic [7:0]  mbc_bank;
    logic        ram_enabled, has_battery, cap_wr, cap_busy;
    logic [3:0]  ram_mask;
    logic [6:0]  rom_mask;
    logic [12:0] cap_addr;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk_sys = ~clk_sys;

    gb_camera_ctrl #(.CAP_BASE_CYCLES(BASE)) dut (
        .clk_sys(clk_sys), .reset(reset), .enable(enable), .ce_cpu(ce_cpu),
        .cart_addr(cart_addr), .cart_wr(cart_wr), .cart_di(cart_di), .cram_di(cram_di),
        .cram_do(cram_do), .cram_addr(cram_addr), .mbc_bank(mbc_bank),
        .ram_enabled(ram_enabled), .has_battery(has_battery), .ram_mask(ram_mask),
        .rom_mask(rom_mask), .cap_wr(cap_wr), .cap_addr(cap_addr), .cap_data(cap_data),
        .cap_ack(cap_ack), .cap_busy(cap_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cart_addr = a;
        cart_di   = d;
        cart_wr   = 1'b1;
        tick();
        cart_wr   = 1'b0;
    endtask

    // Acknowledge continuously and collect the whole fill burst.
    task automatic run_fill(input logic [7:0] frame, input logic [7:0] exp_1ff, input logic [7:0] exp_eff);
        int          beats;
        int          last_i;
        int          i;
        bit          order_ok;
        logic [12:0] expa;
        logic [7:0]  d1ff, deff;
        beats = 0; last_i = 0; order_ok = 1'b1; expa = 13'h0100; d1ff = 8'h00; deff = 8'h00;
        cap_ack = 1'b1;
        for (i = 0; i < 8000 && cap_busy; i++) begin
            if (cap_wr) begin
                if (cap_addr !== expa || cap_data !== (expa[7:0] ^ frame)) order_ok = 1'b0;
                if (cap_addr == 13'h01FF) d1ff = cap_data;
                if (cap_addr == 13'h0EFF) deff = cap_data;
                expa++;
                beats++;
                last_i = i;
            end
            tick();
        end
        cap_ack = 1'b0;
        check("fill_beats", beats, 3584);
        check("fill_order", order_ok, 1);
        check("fill_1ff", d1ff, exp_1ff);
        check("fill_eff", deff, exp_eff);
        check("fill_cycles", i, 7167);
        check("fill_busy_drop", i - last_i, 1);
    endtask

    initial begin
        int          n;
        logic [12:0] sv_addr;
        bit          stable;
        reset = 1'b1; enable = 1'b1; ce_cpu = 1'b1; cart_wr = 1'b0; cart_addr = 16'h4000;
        cart_di = 8'h00; cram_di = 8'h5A; cap_ack = 1'b0; ram_mask = 4'hF; rom_mask = 7'h7F;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_busy", cap_busy, 0);
        check("rst_ram_en", ram_enabled, 0);
        check("rst_cap_wr", cap_wr, 0);
        check("rst_battery", has_battery, 1);
        check("rst_mbc", mbc_bank, 8'h02);
        check("rst_cap_data", cap_data, 8'h00);
`ifdef GB_CAMERA_TESTPATTERN_EN
        check("rst_cap_addr", cap_addr, 13'h0100);
`else
        check("rst_cap_addr", cap_addr, 13'h0000);
`endif

        // banking
        wr(16'h2000, 8'h45);
        cart_addr = 16'h4000; #1;
        check("mbc_45", mbc_bank, 8'h8A);
        rom_mask = 7'h1F; #1;
        check("mbc_mask", mbc_bank, 8'h0A);
        cart_addr = 16'h6000; #1;
        check("mbc_mask_a13", mbc_bank, 8'h0B);
        cart_addr = 16'h1000; #1;
        check("mbc_low_bank0", mbc_bank, 8'h00);
        rom_mask = 7'h7F;
        tick();
        ce_cpu = 1'b0;
        wr(16'h2000, 8'h12);
        ce_cpu = 1'b1;
        cart_addr = 16'h4000; #1;
        check("mbc_no_ce", mbc_bank, 8'h8A);
        tick();
        wr(16'h0000, 8'h0A);
        wr(16'h4000, 8'h03);
        cart_addr = 16'hA123; #1;
        check("cram_addr_b3", cram_addr, 17'h06123);
        check("ram_en_on", ram_enabled, 1);
        check("cram_do_ram", cram_do, 8'h5A);
        ram_mask = 4'h1; #1;
        check("cram_addr_mask", cram_addr, 17'h02123);
        ram_mask = 4'hF;
        tick();
        wr(16'h0000, 8'h0B);
        check("ram_en_off", ram_enabled, 0);
        wr(16'h0000, 8'h0A);

        // base timing capture
        wr(16'h4000, 8'h10);
        check("cam_ram_lock", ram_enabled, 0);
        wr(16'hA001, 8'h80);
        wr(16'hA002, 8'h00);
        wr(16'hA003, 8'h00);
        cart_addr = 16'hA001; #1;
        check("cam_rd_idx1", cram_do, 8'h00);
        tick();
        wr(16'hA000, 8'h07);
        check("start_busy", cap_busy, 1);
        check("rd_busy", cram_do, 8'h07);
        n = 0;
        while (cap_busy && !cap_wr && n < BASE + 100) begin
            cart_wr = (n == 100);
            cart_di = 8'h01;
            if (n == 102) check("rd_rewrite", cram_do, 8'h01);
            n++;
            tick();
        end
        cart_wr = 1'b0;
        check("dur_base", n, BASE);
`ifdef GB_CAMERA_TESTPATTERN_EN
        check("fill0_wr", cap_wr, 1);
        check("fill0_addr", cap_addr, 13'h0100);
        check("fill0_data", cap_data, 8'h00);
        sv_addr = cap_addr; stable = 1'b1; cap_ack = 1'b0;
        repeat (10) begin
            tick();
            if (!cap_wr || cap_addr !== sv_addr || cap_data !== 8'h00) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        run_fill(8'h00, 8'hFF, 8'hFF);
`endif
        check("done_busy", cap_busy, 0);
        check("rd_after", cram_do, 8'h00);

        // exposure capture with mid-capture rewrite and RAM lockout
        wr(16'hA001, 8'h00);
        wr(16'hA002, 8'h00);
        wr(16'hA003, 8'h10);
        wr(16'hA000, 8'h01);
        n = 0;
        while (cap_busy && !cap_wr && n < BASE + 1000) begin
            cart_wr = 1'b0;
            if (n == 50) begin cart_addr = 16'hA003; cart_di = 8'hFF; cart_wr = 1'b1; end
            if (n == 60) begin cart_addr = 16'h4000; cart_di = 8'h00; cart_wr = 1'b1; end
            if (n == 70) begin cart_addr = 16'h0000; cart_di = 8'h0A; cart_wr = 1'b1; end
            if (n == 72) cart_addr = 16'hA000;
            if (n == 80) begin
                check("lock_ram_en", ram_enabled, 0);
                check("lock_rd", cram_do, 8'h00);
            end
            n++;
            tick();
        end
        cart_wr = 1'b0;
        check("dur_exp", n, BASE + 768);
`ifdef GB_CAMERA_TESTPATTERN_EN
        check("fill1_addr", cap_addr, 13'h0100);
        check("fill1_data", cap_data, 8'h01);
        run_fill(8'h01, 8'hFE, 8'hFE);
`endif
        check("unlock_ram_en", ram_enabled, 1);
        check("unlock_rd", cram_do, 8'h5A);

        // abort via enable
        wr(16'h4000, 8'h10);
        wr(16'hA003, 8'h01);
        wr(16'hA001, 8'h80);
        wr(16'hA000, 8'h01);
`ifdef GB_CAMERA_TESTPATTERN_EN
        n = 0;
        while (!cap_wr && n < BASE + 100) begin n++; tick(); end
        check("abort_in_fill", cap_wr, 1);
        cap_ack = 1'b1;
        repeat (9) tick();
        cap_ack = 1'b0;
`else
        repeat (20) tick();
`endif
        check("abort_pre_busy", cap_busy, 1);
        enable = 1'b0;
        tick();
        cart_addr = 16'h4000; #1;
        check("abort_wr", cap_wr, 0);
        check("abort_busy", cap_busy, 0);
        check("abort_mbc", mbc_bank, 8'h02);
        enable = 1'b1;
        tick();
        check("abort_mbc_after", mbc_bank, 8'h02);
`ifdef GB_CAMERA_TESTPATTERN_EN
        wr(16'h4000, 8'h10);
        wr(16'hA001, 8'h80);
        wr(16'hA000, 8'h01);
        n = 0;
        while (cap_busy && !cap_wr && n < BASE + 100) begin n++; tick(); end
        check("restart_dur", n, BASE);
        check("restart_addr", cap_addr, 13'h0100);
        check("restart_data", cap_data, 8'h00);
`else
        wr(16'h4000, 8'h10);
        wr(16'hA001, 8'h80);
        wr(16'hA000, 8'h01);
        check("restart_busy", cap_busy, 1);
`endif
        reset = 1'b1;
        tick();
        check("reset_abort_busy", cap_busy, 0);
        check("reset_abort_wr", cap_wr, 0);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
